// File: rtl/angle_rom_lut_arb_if.sv
// Bus bundle for the shared angle-ROM lookup engine: per-channel request and
// response handshakes plus the ROM address/data pair.
interface angle_rom_lut_arb_if #(
  parameter int N_CH       = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int PW         = 12
);
  logic [N_CH-1:0]                 req_valid;
  logic [N_CH-1:0]                 req_ready;
  logic [N_CH-1:0][PW-1:0]         req_phase;
  logic [ADDR_WIDTH-1:0]           rom_addr;
  logic [DATA_WIDTH-1:0]           rom_rd_data;
  logic [N_CH-1:0]                 rsp_valid;
  logic [N_CH-1:0]                 rsp_ready;
  logic [N_CH-1:0][DATA_WIDTH-1:0] rsp_data;
  logic                            busy;

  modport master (
    output req_valid, req_phase, rom_rd_data, rsp_ready,
    input  req_ready, rom_addr, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_phase, rom_rd_data, rsp_ready,
    output req_ready, rom_addr, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/angle_rom_lut_arb.sv
// Round-robin multi-channel front end for one single-port angle ROM, with
// optional quarter-wave folding and a 1-entry response buffer per channel.
module angle_rom_lut_arb_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  rsp_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data
);
  // load and pop never coincide: a channel is only issued with rsp_valid low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

module angle_rom_lut_arb #(
  parameter  int N_CH       = 4,
  parameter  int ADDR_WIDTH = 10,
  parameter  int DATA_WIDTH = 16,
  parameter  int ROM_LAT    = 1,
  parameter  int FOLD_EN    = 1,
  localparam int PW         = ADDR_WIDTH + 2*FOLD_EN
) (
  input logic                clk,
  input logic                rst_n,
  angle_rom_lut_arb_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]                 inflight, elig, gnt;
  logic [N_CH-1:0]                 rsp_valid_l;
  logic [N_CH-1:0][DATA_WIDTH-1:0] rsp_data_l;
  logic [CH_W-1:0]                 ptr, gnt_idx, lo_idx, hi_idx;
  logic                            gnt_any, lo_any, hi_any;
  logic [PW-1:0]                   gnt_phase;
  logic [ADDR_WIDTH-1:0]           gnt_addr;
  logic                            gnt_sgn;
  logic [DATA_WIDTH-1:0]           rd_data;

  // Tag pipeline: stage s is valid in cycle C+1+s after a handshake in C
  logic [ROM_LAT:0]           vld_pipe;
  logic [ROM_LAT:0][CH_W-1:0] ch_pipe;
  logic [ROM_LAT:0]           sgn_pipe;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < N_CH; i++)
      for (int s = 0; s <= ROM_LAT; s++)
        if (vld_pipe[s] && ch_pipe[s] == CH_W'(i)) inflight[i] = 1'b1;
  end

  assign elig = bus.req_valid & ~inflight & ~rsp_valid_l & {N_CH{rst_n}};

  // Round robin as two priority scans: lowest eligible at/after ptr, else lowest overall
  always_comb begin
    lo_idx = '0;
    lo_any = 1'b0;
    hi_idx = '0;
    hi_any = 1'b0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_idx = CH_W'(i);
        lo_any = 1'b1;
      end
      if (elig[i] && CH_W'(i) >= ptr) begin
        hi_idx = CH_W'(i);
        hi_any = 1'b1;
      end
    end
    gnt_any = lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
    gnt     = '0;
    for (int i = 0; i < N_CH; i++)
      gnt[i] = gnt_any && (gnt_idx == CH_W'(i));
  end

  always_comb begin
    gnt_phase = '0;
    for (int i = 0; i < N_CH; i++)
      if (gnt[i]) gnt_phase = bus.req_phase[i];
  end

  generate
    if (FOLD_EN != 0) begin : g_fold
      // Odd quadrants run the table backwards; upper half-circle negates
      assign gnt_addr = gnt_phase[PW-2] ? ~gnt_phase[ADDR_WIDTH-1:0]
                                        :  gnt_phase[ADDR_WIDTH-1:0];
      assign gnt_sgn  = gnt_phase[PW-1];
    end else begin : g_nofold
      assign gnt_addr = gnt_phase;
      assign gnt_sgn  = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      bus.rom_addr <= '0;
      vld_pipe     <= '0;
      ch_pipe      <= '0;
      sgn_pipe     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ROM_LAT-1:0], gnt_any};
      ch_pipe  <= {ch_pipe[ROM_LAT-1:0], gnt_idx};
      sgn_pipe <= {sgn_pipe[ROM_LAT-1:0], gnt_sgn};
      if (gnt_any) begin
        bus.rom_addr <= gnt_addr;
        ptr          <= (gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + CH_W'(1);
      end
    end
  end

  // Two's complement wrap: negating the most negative word returns it unchanged
  assign rd_data = sgn_pipe[ROM_LAT] ? -bus.rom_rd_data : bus.rom_rd_data;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    angle_rom_lut_arb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (vld_pipe[ROM_LAT] && ch_pipe[ROM_LAT] == CH_W'(i)),
      .load_data (rd_data),
      .rsp_ready (bus.rsp_ready[i]),
      .rsp_valid (rsp_valid_l[i]),
      .rsp_data  (rsp_data_l[i])
    );
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_l;
  assign bus.rsp_data  = rsp_data_l;
  assign bus.busy      = (|vld_pipe) | (|rsp_valid_l);
endmodule
